// File: rtl/ksk_bram_loader.sv
// Fill stage for ksk_bram_bank: streams BEAT_LANES-lane beats into NUM_LANE-lane rows
// through a lane write mask, one registered write per accepted beat.
module ksk_bram_loader #(
  parameter int unsigned NUM_LANE   = 128,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BEAT_LANES = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            num_rows,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH*BEAT_LANES-1:0] s_data,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_wen,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  output logic [NUM_LANE-1:0]            bram_wmask,
  output logic [DATA_WIDTH*NUM_LANE-1:0] bram_wdata
);

  localparam int unsigned NGRP = NUM_LANE / BEAT_LANES;
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned BW   = DATA_WIDTH * BEAT_LANES;
  localparam int unsigned RW   = ADDR_WIDTH + 1;

  localparam logic [RW-1:0] DepthW  = RW'(DEPTH);
  localparam logic [GW-1:0] LastGrp = GW'(NGRP - 1);

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e                      state_q;
  logic [ADDR_WIDTH-1:0]       base_q;
  logic [RW-1:0]               rows_q;
  logic [RW-1:0]               row_q;
  logic [GW-1:0]               grp_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        wen_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [NUM_LANE-1:0]         mask_q;
  logic [DATA_WIDTH*NUM_LANE-1:0] wdata_q;

  logic                        accept;
  logic                        last_beat;
  logic [RW-1:0]               rows_sat;
  logic [RW-1:0]               addr_sum;
  logic [RW-1:0]               addr_wrap;
  logic [NUM_LANE-1:0]         beat_mask;
  logic [DATA_WIDTH*NUM_LANE-1:0] beat_data;

  always_comb begin
    accept    = s_valid && (state_q == StLoad);
    last_beat = (grp_q == LastGrp) && (row_q == rows_q - 1'b1);
    rows_sat  = (num_rows > DepthW) ? DepthW : num_rows;
    // Row offset is always < DEPTH, so a single conditional subtract wraps the address.
    addr_sum  = {1'b0, base_q} + row_q;
    addr_wrap = (addr_sum >= DepthW) ? (addr_sum - DepthW) : addr_sum;
    beat_mask = '0;
    beat_mask[grp_q*BEAT_LANES +: BEAT_LANES] = '1;
    beat_data = '0;
    beat_data[grp_q*BW +: BW] = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      rows_q  <= '0;
      row_q   <= '0;
      grp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
    end else begin
      wen_q  <= 1'b0;
      mask_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy stays high through the done cycle, so a start there is dropped.
          if (done_q) begin
            busy_q <= 1'b0;
          end
          if (start && !busy_q) begin
            base_q <= base_addr;
            rows_q <= rows_sat;
            row_q  <= '0;
            grp_q  <= '0;
            if (rows_sat == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StLoad;
              busy_q  <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            wen_q   <= 1'b1;
            addr_q  <= addr_wrap[ADDR_WIDTH-1:0];
            mask_q  <= beat_mask;
            wdata_q <= beat_data;
            if (grp_q == LastGrp) begin
              grp_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              grp_q <= grp_q + 1'b1;
            end
            if (last_beat) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_ready    = (state_q == StLoad);
  assign busy       = busy_q;
  assign done       = done_q;
  assign bram_wen   = wen_q;
  assign bram_addr  = addr_q;
  assign bram_wmask = mask_q;
  assign bram_wdata = wdata_q;

endmodule

// File: tb/tb_ksk_bram_loader.sv
// Bench for ksk_bram_loader: random beat data and valid patterns checked against a
// queue of expected bank writes derived from job base/rows and beat index.
module tb_ksk_bram_loader;

  localparam int NUM_LANE   = 128;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH      = 4096;
  localparam int DATA_WIDTH = 64;
  localparam int BEAT_LANES = 8;
  localparam int NGRP       = NUM_LANE / BEAT_LANES;
  localparam int BW         = DATA_WIDTH * BEAT_LANES;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           start;
  logic [ADDR_WIDTH-1:0]          base_addr;
  logic [ADDR_WIDTH:0]            num_rows;
  logic                           s_valid;
  logic                           s_ready;
  logic [BW-1:0]                  s_data;
  logic                           busy;
  logic                           done;
  logic                           bram_wen;
  logic [ADDR_WIDTH-1:0]          bram_addr;
  logic [NUM_LANE-1:0]            bram_wmask;
  logic [DATA_WIDTH*NUM_LANE-1:0] bram_wdata;

  ksk_bram_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .busy       (busy),
    .done       (done),
    .bram_wen   (bram_wen),
    .bram_addr  (bram_addr),
    .bram_wmask (bram_wmask),
    .bram_wdata (bram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    int                    g;
    logic [BW-1:0]         data;
    bit                    last;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  bit  bare_ok = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every bank write must match the next expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_wen) begin
        if (q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          wr_t e;
          logic [NUM_LANE-1:0] m;
          logic [DATA_WIDTH*NUM_LANE-1:0] wd;
          e = q.pop_front();
          m = '0;
          for (int k = 0; k < BEAT_LANES; k++) m[e.g*BEAT_LANES+k] = 1'b1;
          wd = '0;
          wd[e.g*BW +: BW] = e.data;
          check("addr", 128'(bram_addr), 128'(e.addr));
          check("wmask", bram_wmask, m);
          check("done_with_write", 128'(done), 128'(e.last));
          checks++;
          assert (bram_wdata === wd) else begin
            errors++;
            $error("FAIL wdata g=%0d got=%h exp=%h", e.g, bram_wdata[e.g*BW +: BW], e.data);
          end
        end
      end else begin
        check("idle_wmask", bram_wmask, 0);
        if (!bare_ok) check("idle_done", 128'(done), 0);
      end
      if (done) done_cnt++;
    end
  end

  // mode: 0 valid always high, 1 alternating 1-0, 2 random.
  task automatic run_job(input int base, input int rows, input int mode,
                         input int abort_after, input int inject_at);
    int jr, total, n, cyc, d0;
    bit got;
    jr    = (rows > DEPTH) ? DEPTH : rows;
    total = jr * NGRP;
    n     = 0;
    cyc   = 0;
    d0    = done_cnt;
    if (total == 0) bare_ok = 1;
    start = 1; base_addr = ADDR_WIDTH'(base); num_rows = (ADDR_WIDTH+1)'(rows);
    @(posedge clk); #1 start = 0;
    if (total == 0) begin
      @(negedge clk);
      check("zero_done", 128'(done), 1);
      check("zero_busy", 128'(busy), 0);
      check("zero_wen", 128'(bram_wen), 0);
      @(negedge clk);
      check("zero_done_clr", 128'(done), 0);
      check("zero_busy2", 128'(busy), 0);
      bare_ok = 0;
      @(posedge clk); #1;
      return;
    end
    @(negedge clk);
    check("busy_after_start", 128'(busy), 1);
    check("ready_in_load", 128'(s_ready), 1);
    @(posedge clk); #1;
    while (n < total && cyc < total * 4 + 100) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      for (int w = 0; w < BW / 32; w++) s_data[w*32 +: 32] = $urandom;
      if (inject_at >= 0 && n == inject_at) begin
        start = 1; base_addr = 100; num_rows = 3;
      end else begin
        start = 0;
      end
      @(negedge clk);
      if (s_valid && s_ready) begin
        wr_t e;
        e.addr = ADDR_WIDTH'((base + n / NGRP) % DEPTH);
        e.g    = n % NGRP;
        e.data = s_data;
        e.last = (n == total - 1);
        q.push_back(e);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && n == abort_after) begin
        rst_n = 0; s_valid = 0; start = 0;
        #1;
        check("rst_wen", 128'(bram_wen), 0);
        check("rst_addr", 128'(bram_addr), 0);
        check("rst_wmask", bram_wmask, 0);
        check("rst_busy", 128'(busy), 0);
        check("rst_done", 128'(done), 0);
        check("rst_ready", 128'(s_ready), 0);
        checks++;
        assert (bram_wdata === '0) else begin
          errors++;
          $error("FAIL rst_wdata got nonzero exp=0");
        end
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        return;
      end
    end
    s_valid = 0; start = 0;
    check("beats_accepted", 128'(n), 128'(total));
    if (mode == 0) check("sustained_rate", 128'(cyc), 128'(total));
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check("done_seen", 128'(got), 1);
    check("busy_on_done", 128'(busy), 1);
    start = 1; num_rows = 1; base_addr = 0;  // must be ignored: busy still high
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    check("busy_after_done", 128'(busy), 0);
    check("start_on_done_ignored", 128'(s_ready), 0);
    @(posedge clk); #1;
    check("done_once", 128'(done_cnt - d0), 1);
    check("queue_drained", 128'(q.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; base_addr = 0; num_rows = 0; s_valid = 0; s_data = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 128'(s_ready), 0);
    check("reset_busy", 128'(busy), 0);
    check("reset_wen", 128'(bram_wen), 0);
    check("reset_wmask", bram_wmask, 0);
    rst_n = 1;
    @(posedge clk); #1;

    run_job(0, 2, 0, 0, -1);
    run_job(0, 2, 1, 0, -1);
    run_job(4095, 2, 2, 0, -1);
    run_job(0, 0, 0, 0, -1);
    run_job(0, 2, 0, 5, -1);
    run_job(7, 1, 2, 0, -1);
    for (int j = 0; j < 3; j++) begin
      run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 3)), 2, 0, -1);
    end
    run_job(0, 5000, 0, 0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
